// File: rtl/proc_datapath.sv
// ---------------------------------------------------------------------------
// proc_datapath
//   Datapath stage driven by the processor control FSM. Executes the per-cycle
//   control strobes: shared bus, R0..R6, R7 (program counter), IR, and the
//   A/G adder-subtractor with zero/carry flags. Bus contention is detected and
//   latched in a sticky error flag.
//
// Ports
//   Clock     in   rising-edge system clock
//   Resetn    in   synchronous active-low reset
//   DIN       in   data/instruction word from memory
//   Rout      in   one-hot bus source select, R7..R0
//   Rin       in   register load enables, R7..R0
//   Gout      in   G drives the bus
//   DINout    in   DIN drives the bus
//   IRin      in   load IR from DIN
//   Ain       in   load A from the bus
//   Gin       in   load G with ALU result, update flags
//   AddSub    in   0 = add, 1 = subtract
//   pc_inc    in   increment R7
//   IRout     out  instruction register
//   BusWires  out  current bus value (combinational)
//   ADDR      out  current PC (R7)
//   Zflag     out  last ALU result was zero
//   Cflag     out  add carry-out / subtract borrow
//   BusErr    out  sticky bus-contention flag
// ---------------------------------------------------------------------------
module proc_datapath #(
   parameter int               WIDTH    = 9,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [WIDTH-1:0] DIN,
   input  logic [7:0]       Rout,
   input  logic [7:0]       Rin,
   input  logic             Gout,
   input  logic             DINout,
   input  logic             IRin,
   input  logic             Ain,
   input  logic             Gin,
   input  logic             AddSub,
   input  logic             pc_inc,
   output logic [WIDTH-1:0] IRout,
   output logic [WIDTH-1:0] BusWires,
   output logic [WIDTH-1:0] ADDR,
   output logic             Zflag,
   output logic             Cflag,
   output logic             BusErr
);

   logic [WIDTH-1:0] r_reg [0:7];
   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_g;
   logic             r_z;
   logic             r_c;
   logic             r_buserr;

   logic [9:0]       w_sel;
   logic             w_multi;
   logic [WIDTH-1:0] w_bus_or;
   logic [WIDTH-1:0] w_bus;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_alu;
   logic             w_cout;

   // Two or more selects set: x & (x-1) clears the lowest set bit, so any
   // remaining bit means contention.
   assign w_sel   = {Rout, Gout, DINout};
   assign w_multi = |(w_sel & (w_sel - 10'd1));

   // AND-OR mux; exact for a single select, forced to zero on contention.
   always_comb begin
      w_bus_or = '0;
      for (int i = 0; i < 8; i++)
         if (Rout[i]) w_bus_or = w_bus_or | r_reg[i];
      if (Gout)   w_bus_or = w_bus_or | r_g;
      if (DINout) w_bus_or = w_bus_or | DIN;
   end

   assign w_bus = w_multi ? '0 : w_bus_or;

   // Extra MSB gives add carry-out; for subtract it is set when A < bus,
   // which is exactly the unsigned borrow.
   assign w_sum  = {1'b0, r_a} + {1'b0, w_bus};
   assign w_diff = {1'b0, r_a} - {1'b0, w_bus};
   assign w_alu  = AddSub ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
   assign w_cout = AddSub ? w_diff[WIDTH]     : w_sum[WIDTH];

   // All reads use pre-edge values, so Ain+Gin sees the old A, Gout+Gin
   // routes the old G, and Rout[i]+Rin[i] reloads the register's own value.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         for (int i = 0; i < 7; i++) r_reg[i] <= '0;
         r_reg[7] <= PC_RESET;
         r_ir     <= '0;
         r_a      <= '0;
         r_g      <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_buserr <= 1'b0;
      end else begin
         for (int i = 0; i < 7; i++)
            if (Rin[i]) r_reg[i] <= w_bus;
         // Explicit PC load beats increment.
         if (Rin[7])      r_reg[7] <= w_bus;
         else if (pc_inc) r_reg[7] <= r_reg[7] + {{(WIDTH-1){1'b0}}, 1'b1};
         if (IRin) r_ir <= DIN;
         if (Ain)  r_a  <= w_bus;
         if (Gin) begin
            r_g <= w_alu;
            r_z <= (w_alu == '0);
            r_c <= w_cout;
         end
         if (w_multi) r_buserr <= 1'b1;
      end
   end

   assign IRout    = r_ir;
   assign BusWires = w_bus;
   assign ADDR     = r_reg[7];
   assign Zflag    = r_z;
   assign Cflag    = r_c;
   assign BusErr   = r_buserr;

endmodule

// File: tb/tb_proc_datapath.sv
module tb_proc_datapath;

   logic       Clock = 1'b0;
   logic       Resetn;
   logic [8:0] DIN;
   logic [7:0] Rout, Rin;
   logic       Gout, DINout, IRin, Ain, Gin, AddSub, pc_inc;
   logic [8:0] IRout, BusWires, ADDR;
   logic       Zflag, Cflag, BusErr;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   proc_datapath #(.WIDTH(9), .PC_RESET(9'h000)) dut (
      .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Rout(Rout), .Rin(Rin),
      .Gout(Gout), .DINout(DINout), .IRin(IRin), .Ain(Ain), .Gin(Gin),
      .AddSub(AddSub), .pc_inc(pc_inc), .IRout(IRout), .BusWires(BusWires),
      .ADDR(ADDR), .Zflag(Zflag), .Cflag(Cflag), .BusErr(BusErr)
   );

   task automatic idle();
      Rout = 8'h00; Rin = 8'h00; Gout = 1'b0; DINout = 1'b0; IRin = 1'b0;
      Ain = 1'b0; Gin = 1'b0; AddSub = 1'b0; pc_inc = 1'b0; DIN = 9'h000;
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // mvi Rk, val
   task automatic load(input int k, input logic [8:0] val);
      idle();
      DINout = 1'b1; DIN = val; Rin = 8'(1 << k);
      step();
      idle();
   endtask

   // A <= Rx; G <= A op Ry
   task automatic alu_op(input int x, input int y, input logic sub);
      idle(); Rout = 8'(1 << x); Ain = 1'b1; step();
      idle(); Rout = 8'(1 << y); Gin = 1'b1; AddSub = sub; step();
      idle();
   endtask

   task automatic test_reset();
      idle();
      Resetn = 1'b0; Rin = 8'hFF; DINout = 1'b1; DIN = 9'h1AA;
      step();
      Resetn = 1'b1; idle();
      #1;
      total++; if (ADDR !== 9'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", ADDR); end
      total++; if (IRout !== 9'h000) begin bad++; $display("FAIL reset_ir got=%h exp=000", IRout); end
      total++; if ({BusErr, Zflag, Cflag} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {BusErr, Zflag, Cflag}); end
      for (int i = 0; i < 7; i++) begin
         Rout = 8'(1 << i); #1;
         total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL reset_r%0d got=%h exp=000", i, BusWires); end
      end
      Rout = 8'h00; Gout = 1'b1; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL reset_g got=%h exp=000", BusWires); end
      idle();
   endtask

   task automatic test_mvi_mv();
      idle(); DINout = 1'b1; DIN = 9'h005; Rin = 8'h01; #1;
      total++; if (BusWires !== 9'h005) begin bad++; $display("FAIL mvi_bus got=%h exp=005", BusWires); end
      step(); idle();
      Rout = 8'h01; Rin = 8'h08; #1;
      total++; if (BusWires !== 9'h005) begin bad++; $display("FAIL mvi_r0 got=%h exp=005", BusWires); end
      step(); idle();
      Rout = 8'h08; #1;
      total++; if (BusWires !== 9'h005) begin bad++; $display("FAIL mv_r3 got=%h exp=005", BusWires); end
      Rout = 8'h01; #1;
      total++; if (BusWires !== 9'h005) begin bad++; $display("FAIL mv_r0_kept got=%h exp=005", BusWires); end
      // mv R3,R3 is a no-op
      Rout = 8'h08; Rin = 8'h08; step(); idle();
      Rout = 8'h08; #1;
      total++; if (BusWires !== 9'h005) begin bad++; $display("FAIL mv_self got=%h exp=005", BusWires); end
      idle();
   endtask

   task automatic test_add();
      load(0, 9'h005); load(1, 9'h003);
      alu_op(0, 1, 1'b0);
      Gout = 1'b1; Rin = 8'h04; step(); idle();
      Rout = 8'h04; #1;
      total++; if (BusWires !== 9'h008) begin bad++; $display("FAIL add_r2 got=%h exp=008", BusWires); end
      total++; if ({Zflag, Cflag} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b exp=00", {Zflag, Cflag}); end
      load(0, 9'h1FF); load(1, 9'h001);
      alu_op(0, 1, 1'b0);
      Gout = 1'b1; Rin = 8'h04; step(); idle();
      Rout = 8'h04; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL add_wrap_r2 got=%h exp=000", BusWires); end
      total++; if ({Zflag, Cflag} !== 2'b11) begin bad++; $display("FAIL add_wrap_flags got=%b exp=11", {Zflag, Cflag}); end
      idle();
   endtask

   task automatic test_sub();
      load(0, 9'h003); load(1, 9'h005);
      alu_op(0, 1, 1'b1);
      Gout = 1'b1; #1;
      total++; if (BusWires !== 9'h1FE) begin bad++; $display("FAIL sub_neg_g got=%h exp=1fe", BusWires); end
      total++; if ({Zflag, Cflag} !== 2'b01) begin bad++; $display("FAIL sub_neg_flags got=%b exp=01", {Zflag, Cflag}); end
      load(0, 9'h007); load(1, 9'h007);
      alu_op(0, 1, 1'b1);
      Gout = 1'b1; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL sub_eq_g got=%h exp=000", BusWires); end
      total++; if ({Zflag, Cflag} !== 2'b10) begin bad++; $display("FAIL sub_eq_flags got=%b exp=10", {Zflag, Cflag}); end
      idle();
   endtask

   task automatic test_hazards();
      // A=7 from test_sub; loads without Gin must not touch flags
      load(0, 9'h002);
      total++; if ({Zflag, Cflag} !== 2'b10) begin bad++; $display("FAIL flags_hold got=%b exp=10", {Zflag, Cflag}); end
      // Ain+Gin: G = old A (7) + 2 = 9, A becomes 2
      Rout = 8'h01; Ain = 1'b1; Gin = 1'b1; step(); idle();
      Gout = 1'b1; #1;
      total++; if (BusWires !== 9'h009) begin bad++; $display("FAIL ain_gin got=%h exp=009", BusWires); end
      // Gout+Gin: G = A (2) + old G (9) = 11
      Gin = 1'b1; step(); idle();
      Gout = 1'b1; #1;
      total++; if (BusWires !== 9'h00B) begin bad++; $display("FAIL gout_gin got=%h exp=00b", BusWires); end
      idle();
   endtask

   task automatic test_pc();
      load(7, 9'h1FF);
      total++; if (ADDR !== 9'h1FF) begin bad++; $display("FAIL pc_load got=%h exp=1ff", ADDR); end
      pc_inc = 1'b1; step(); idle();
      total++; if (ADDR !== 9'h000) begin bad++; $display("FAIL pc_wrap got=%h exp=000", ADDR); end
      Rin = 8'h80; DINout = 1'b1; DIN = 9'h040; pc_inc = 1'b1; step(); idle();
      total++; if (ADDR !== 9'h040) begin bad++; $display("FAIL pc_load_prio got=%h exp=040", ADDR); end
      IRin = 1'b1; pc_inc = 1'b1; DIN = 9'h0C8; step(); idle();
      total++; if (IRout !== 9'h0C8) begin bad++; $display("FAIL fetch_ir got=%h exp=0c8", IRout); end
      total++; if (ADDR !== 9'h041) begin bad++; $display("FAIL fetch_pc got=%h exp=041", ADDR); end
      step();
      total++; if (ADDR !== 9'h041) begin bad++; $display("FAIL pc_hold got=%h exp=041", ADDR); end
   endtask

   task automatic test_contention();
      total++; if (BusErr !== 1'b0) begin bad++; $display("FAIL buserr_pre got=%b exp=0", BusErr); end
      load(4, 9'h077);
      Rout = 8'h03; Rin = 8'h10; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL cont_bus got=%h exp=000", BusWires); end
      step(); idle();
      total++; if (BusErr !== 1'b1) begin bad++; $display("FAIL cont_set got=%b exp=1", BusErr); end
      Rout = 8'h10; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL cont_r4 got=%h exp=000", BusWires); end
      step(); idle();
      total++; if (BusErr !== 1'b1) begin bad++; $display("FAIL cont_sticky got=%b exp=1", BusErr); end
      Gout = 1'b1; DINout = 1'b1; DIN = 9'h155; #1;
      total++; if (BusWires !== 9'h000) begin bad++; $display("FAIL cont_g_din got=%h exp=000", BusWires); end
      step(); idle();
      Resetn = 1'b0; step(); Resetn = 1'b1;
      total++; if (BusErr !== 1'b0) begin bad++; $display("FAIL cont_clear got=%b exp=0", BusErr); end
      total++; if (ADDR !== 9'h000) begin bad++; $display("FAIL rst_pc got=%h exp=000", ADDR); end
   endtask

   initial begin
      Resetn = 1'b1;
      idle();
      #2;
      test_reset();
      test_mvi_mv();
      test_add();
      test_sub();
      test_hazards();
      test_pc();
      test_contention();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
